// File: rtl/pcie_pkg.sv
// rtl/pcie_pkg.sv - shared PCIe TLP types and constants for the TX serializer
package pcie_pkg;

    localparam int TLP_HDR_DW          = 4;
    localparam int DEF_DATA_WIDTH      = 256;
    localparam int DEF_CHUNK_MAX_BEATS = 4;

    function automatic int max_payload_dw(input int chunk_beats, input int data_width);
        return chunk_beats * data_width / 32;
    endfunction

    localparam int MAX_PAYLOAD_DW = max_payload_dw(DEF_CHUNK_MAX_BEATS, DEF_DATA_WIDTH);

    typedef struct packed {
        logic [DEF_DATA_WIDTH-1:0]    data;
        logic [DEF_DATA_WIDTH/32-1:0] keep;
        logic                         sop;
        logic                         eop;
    } tlp_tx_beat_t;

    typedef enum logic {
        IDLE,
        SEND
    } tlp_ser_state_e;

endpackage

// File: rtl/pcie_tlp_tx_serializer_keep.sv
// rtl/pcie_tlp_tx_serializer_keep.sv - remaining-DW to per-DW keep / end-of-packet decode
module tlp_beat_keep #(
    parameter int BEAT_DW = 8,
    parameter int RW      = 11
) (
    input  logic [RW-1:0]      remaining,
    output logic [BEAT_DW-1:0] keep,
    output logic               eop
);

    // DW i of the beat is live whenever more than i DWs remain.
    always_comb begin
        keep = '0;
        for (int i = 0; i < BEAT_DW; i++) begin
            keep[i] = (remaining > RW'(i));
        end
    end

    assign eop = (remaining <= RW'(BEAT_DW));

endmodule

// File: rtl/pcie_tlp_tx_serializer.sv
// rtl/pcie_tlp_tx_serializer.sv - whole-TLP to beat serializer; TLP_SER_BACK2BACK_EN enables zero-gap TLPs
module pcie_tlp_tx_serializer
    import pcie_pkg::*;
#(
    parameter int DATA_WIDTH      = 256,
    parameter int CHUNK_MAX_BEATS = 4,
    parameter int HDR_WIDTH       = 128
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [HDR_WIDTH-1:0]                  in_hdr,
    input  logic [DATA_WIDTH*CHUNK_MAX_BEATS-1:0] in_payload,
    input  logic                                  in_has_data,
    input  logic [9:0]                            in_len_dw,
    input  logic                                  in_valid,
    output logic                                  in_ready,
    output logic [DATA_WIDTH-1:0]                 tx_data,
    output logic [DATA_WIDTH/32-1:0]              tx_keep,
    output logic                                  tx_sop,
    output logic                                  tx_eop,
    output logic                                  tx_valid,
    input  logic                                  tx_ready,
    output logic                                  err_len,
    output logic [15:0]                           tlp_cnt
);

    localparam int BEAT_DW = DATA_WIDTH / 32;
    localparam int SR_W    = HDR_WIDTH + DATA_WIDTH * CHUNK_MAX_BEATS;
    localparam int MAX_DW  = max_payload_dw(CHUNK_MAX_BEATS, DATA_WIDTH);
    localparam int RW      = 11;

    tlp_ser_state_e         state;
    logic [SR_W-1:0]        sr, sr_next;
    logic [RW-1:0]          rem, rem_next;
    logic [9:0]             eff_len;
    logic                   len_bad;
    logic                   accept, fire;
    logic [BEAT_DW-1:0]     keep_next;
    logic                   eop_next;
    logic [DATA_WIDTH-1:0]  data_next;

`ifdef TLP_SER_BACK2BACK_EN
    assign in_ready = !rst && ((state == IDLE) || (state == SEND && tx_eop && tx_ready));
`else
    assign in_ready = !rst && (state == IDLE);
`endif

    assign accept = in_valid && in_ready;
    assign fire   = tx_valid && tx_ready;

    always_comb begin
        eff_len = '0;
        len_bad = 1'b0;
        if (in_has_data) begin
            if (in_len_dw == 10'd0) begin
                eff_len = 10'd1;
                len_bad = 1'b1;
            end else if (in_len_dw > 10'(MAX_DW)) begin
                eff_len = 10'(MAX_DW);
                len_bad = 1'b1;
            end else begin
                eff_len = in_len_dw;
            end
        end
    end

    // Next beat is either the first beat of a fresh TLP or the following slice of the current one.
    always_comb begin
        if (accept) begin
            sr_next  = {in_payload, in_hdr};
            rem_next = RW'(TLP_HDR_DW) + RW'(eff_len);
        end else begin
            sr_next  = sr >> DATA_WIDTH;
            rem_next = rem - RW'(BEAT_DW);
        end
    end

    tlp_beat_keep #(
        .BEAT_DW (BEAT_DW),
        .RW      (RW)
    ) u_keep (
        .remaining (rem_next),
        .keep      (keep_next),
        .eop       (eop_next)
    );

    always_comb begin
        data_next = '0;
        for (int i = 0; i < BEAT_DW; i++) begin
            if (keep_next[i]) data_next[i*32 +: 32] = sr_next[i*32 +: 32];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            sr       <= '0;
            rem      <= '0;
            tx_data  <= '0;
            tx_keep  <= '0;
            tx_sop   <= 1'b0;
            tx_eop   <= 1'b0;
            tx_valid <= 1'b0;
            err_len  <= 1'b0;
            tlp_cnt  <= '0;
        end else begin
            if (fire && tx_eop) tlp_cnt <= tlp_cnt + 16'd1;
            if (accept && len_bad) err_len <= 1'b1;
            if (accept || (fire && !tx_eop)) begin
                state    <= SEND;
                sr       <= sr_next;
                rem      <= rem_next;
                tx_data  <= data_next;
                tx_keep  <= keep_next;
                tx_eop   <= eop_next;
                tx_sop   <= accept;
                tx_valid <= 1'b1;
            end else if (fire) begin
                state    <= IDLE;
                tx_data  <= '0;
                tx_keep  <= '0;
                tx_sop   <= 1'b0;
                tx_eop   <= 1'b0;
                tx_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_pcie_tlp_tx_serializer.sv
// tb/tb_pcie_tlp_tx_serializer.sv - self-checking bench for pcie_tlp_tx_serializer
module tb_pcie_tlp_tx_serializer;

    typedef struct {
        logic [255:0] data;
        logic [7:0]   keep;
        logic         sop;
        logic         eop;
    } beat_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [127:0]  in_hdr = '0;
    logic [1023:0] in_payload = '0;
    logic          in_has_data = 1'b0;
    logic [9:0]    in_len_dw = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [255:0]  tx_data;
    logic [7:0]    tx_keep;
    logic          tx_sop, tx_eop, tx_valid;
    logic          tx_ready = 1'b1;
    logic          err_len;
    logic [15:0]   tlp_cnt;

    int total = 0;
    int bad = 0;

    beat_t        exp_q[$];
    beat_t        e;
    int           model_cnt = 0;
    bit           model_err = 0;
    bit           pending_sop = 0;
    bit           held = 0;
    logic [255:0] prev_data;
    logic [7:0]   prev_keep;
    logic         prev_sop, prev_eop;
    int           idle_run = 100;
    int           last_gap = -1;
    int           beats_in_tlp = 0;
    int           last_tlp_beats = 0;
    bit           rand_ready = 0;

    pcie_tlp_tx_serializer dut (
        .clk         (clk),
        .rst         (rst),
        .in_hdr      (in_hdr),
        .in_payload  (in_payload),
        .in_has_data (in_has_data),
        .in_len_dw   (in_len_dw),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .tx_data     (tx_data),
        .tx_keep     (tx_keep),
        .tx_sop      (tx_sop),
        .tx_eop      (tx_eop),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .err_len     (err_len),
        .tlp_cnt     (tlp_cnt)
    );

    always #5 clk = ~clk;

    function void chk(input bit ok, input string name, input logic [255:0] act, input logic [255:0] want);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, want);
        end
    endfunction

    // Reference: lay the TLP out as a flat DW list, then cut it into 8-DW beats.
    function void push_model(input logic [127:0] h, input logic [1023:0] p,
                             input logic hd, input logic [9:0] len);
        int    l, tot, nb, idx;
        beat_t b;
        if (!hd) l = 0;
        else if (len == 0) begin l = 1; model_err = 1; end
        else if (len > 32) begin l = 32; model_err = 1; end
        else l = int'(len);
        tot = 4 + l;
        nb  = (tot + 7) / 8;
        for (int bi = 0; bi < nb; bi++) begin
            b.data = '0;
            b.keep = '0;
            for (int d = 0; d < 8; d++) begin
                idx = bi * 8 + d;
                if (idx < tot) begin
                    b.keep[d] = 1'b1;
                    b.data[d*32 +: 32] = (idx < 4) ? h[idx*32 +: 32] : p[(idx-4)*32 +: 32];
                end
            end
            b.sop = (bi == 0);
            b.eop = (bi == nb - 1);
            exp_q.push_back(b);
        end
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            model_cnt = 0;
            model_err = 0;
            pending_sop = 0;
            held = 0;
            beats_in_tlp = 0;
            chk(!tx_valid && !in_ready, "reset_idle", {tx_valid, in_ready}, 0);
        end else begin
            chk(tlp_cnt == 16'(model_cnt), "tlp_cnt", tlp_cnt, model_cnt);
            chk(err_len == model_err, "err_len", err_len, model_err);
            if (held)
                chk(tx_valid && tx_data == prev_data && tx_keep == prev_keep &&
                    tx_sop == prev_sop && tx_eop == prev_eop, "hold", tx_data, prev_data);
            if (pending_sop) begin
                chk(tx_valid && tx_sop, "latency_sop", {tx_valid, tx_sop}, 2'b11);
                pending_sop = 0;
            end
            if (!tx_valid && exp_q.size() != 0)
                chk(0, "valid_gap", exp_q.size(), 0);
            if (tx_valid && tx_ready) begin
                if (exp_q.size() == 0) begin
                    chk(0, "unexpected_beat", tx_data, 0);
                end else begin
                    e = exp_q.pop_front();
                    total++;
                    if (tx_data !== e.data || tx_keep !== e.keep || tx_sop !== e.sop || tx_eop !== e.eop) begin
                        bad++;
                        $display("FAIL beat: got data=%h keep=%h sop=%b eop=%b want data=%h keep=%h sop=%b eop=%b",
                                 tx_data, tx_keep, tx_sop, tx_eop, e.data, e.keep, e.sop, e.eop);
                    end
                end
                if (tx_sop) last_gap = idle_run;
                idle_run = 0;
                beats_in_tlp++;
                if (tx_eop) begin
                    model_cnt++;
                    last_tlp_beats = beats_in_tlp;
                    beats_in_tlp = 0;
                end
            end else if (!tx_valid) begin
                idle_run++;
            end
            held = tx_valid && !tx_ready;
            prev_data = tx_data;
            prev_keep = tx_keep;
            prev_sop = tx_sop;
            prev_eop = tx_eop;
            if (in_valid && in_ready) begin
                push_model(in_hdr, in_payload, in_has_data, in_len_dw);
                pending_sop = 1;
            end
        end
    end

    always @(posedge clk) begin
        #1;
        if (rand_ready) tx_ready = ($urandom_range(0, 3) != 0);
    end

    // Entered and left at posedge+1; in_valid stays high on return.
    task automatic send(input logic [127:0] h, input logic [1023:0] p, input logic hd, input logic [9:0] len);
        bit got = 0;
        in_hdr = h;
        in_payload = p;
        in_has_data = hd;
        in_len_dw = len;
        in_valid = 1'b1;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (in_ready) begin
                got = 1;
                break;
            end
        end
        if (!got) chk(0, "accept_timeout", 0, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        bit done = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !tx_valid) begin
                done = 1;
                break;
            end
        end
        if (!done) chk(0, "drain_timeout", exp_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    function automatic logic [1023:0] inc_payload();
        logic [1023:0] p;
        for (int k = 0; k < 32; k++) p[k*32 +: 32] = 32'(k);
        return p;
    endfunction

    initial begin
        logic [127:0]  rd_hdr;
        logic [1023:0] p;
        logic [7:0]    keeps[5];
        logic [255:0]  b0, b4;
        int            r;
        logic [9:0]    len;

        rd_hdr = 128'h0000_1000_0000_000F_0000_0000_0000_0000;
        repeat (2) @(negedge clk);
        chk({tx_valid, tx_sop, tx_eop, tx_keep, err_len, tlp_cnt, |tx_data, in_ready} == '0,
            "reset_state", {tx_valid, tx_sop, tx_eop, tx_keep, err_len, tlp_cnt}, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // read TLP: header-only single beat
        send(rd_hdr, '0, 1'b0, 10'd0);
        in_valid = 1'b0;
        @(negedge clk);
        chk(tx_valid && tx_sop && tx_eop, "read_sop_eop", {tx_valid, tx_sop, tx_eop}, 3'b111);
        chk(tx_keep == 8'h0F, "read_keep", tx_keep, 8'h0F);
        chk(tx_data[127:0] == rd_hdr, "read_hdr", tx_data[127:0], rd_hdr);
        chk(tx_data[255:128] == '0, "read_upper", tx_data[255:128], 0);
        wait_idle();

        // 32-DW write, incrementing payload
        p = inc_payload();
        send(128'hA, p, 1'b1, 10'd32);
        in_valid = 1'b0;
        for (int b = 0; b < 5; b++) begin
            @(negedge clk);
            keeps[b] = tx_keep;
            if (b == 0) b0 = tx_data;
            if (b == 4) b4 = tx_data;
        end
        chk({keeps[0], keeps[1], keeps[2], keeps[3], keeps[4]} == 40'hFFFFFFFF0F, "w32_keeps",
            {keeps[0], keeps[1], keeps[2], keeps[3], keeps[4]}, 40'hFFFFFFFF0F);
        chk(b0[159:128] == 32'd0 && b0[255:224] == 32'd3, "w32_beat0", b0[255:128], 128'h3_00000002_00000001_00000000);
        chk(b4[31:0] == 32'd28 && b4[127:96] == 32'd31 && b4[255:128] == '0, "w32_beat4", b4, 0);
        wait_idle();
        chk(tlp_cnt == 16'd2, "tlp_cnt_after_w32", tlp_cnt, 2);

        // 4-DW write fits one full beat
        send(128'hB, p, 1'b1, 10'd4);
        in_valid = 1'b0;
        @(negedge clk);
        chk(tx_valid && tx_sop && tx_eop && tx_keep == 8'hFF, "w4_single", {tx_sop, tx_eop, tx_keep}, 10'h3FF);
        wait_idle();

        // sink stalls three cycles on beat 2
        send(128'hC, p, 1'b1, 10'd32);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        tx_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk(tx_valid && tx_keep == 8'hFF && !tx_sop && !tx_eop && tx_data[31:0] == 32'd12 &&
                tx_data[255:224] == 32'd19, "stall_beat2", tx_data, {32'd19, 192'h0, 32'd12});
        end
        @(posedge clk);
        #1;
        tx_ready = 1'b1;
        wait_idle();
        chk(last_tlp_beats == 5, "stall_beats", last_tlp_beats, 5);

        // two 12-DW writes with in_valid held high
        send(128'hD, p, 1'b1, 10'd12);
        send(128'hE, ~p, 1'b1, 10'd12);
        in_valid = 1'b0;
        wait_idle();
`ifdef TLP_SER_BACK2BACK_EN
        chk(last_gap == 0, "b2b_gap", last_gap, 0);
`else
        chk(last_gap == 1, "b2b_gap", last_gap, 1);
`endif

        // oversize length clamps to 32 DW
        send(128'hF, p, 1'b1, 10'd40);
        in_valid = 1'b0;
        wait_idle();
        chk(last_tlp_beats == 5, "clamp_beats", last_tlp_beats, 5);
        chk(err_len == 1'b1, "clamp_err", err_len, 1);

        // reset asserted during beat 1
        send(128'h10, p, 1'b1, 10'd32);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk(!tx_valid && !err_len && tlp_cnt == 0, "reset_mid", {tx_valid, err_len, tlp_cnt}, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk(!tx_valid && tlp_cnt == 0, "post_reset_quiet", {tx_valid, tlp_cnt}, 0);
        end
        @(posedge clk);
        #1;

        // randomized traffic with random sink backpressure
        rand_ready = 1;
        for (int t = 0; t < 40; t++) begin
            for (int k = 0; k < 32; k++) p[k*32 +: 32] = $urandom();
            r = $urandom_range(0, 9);
            if (r == 0) len = 10'd0;
            else if (r == 1) len = 10'($urandom_range(33, 1023));
            else len = 10'($urandom_range(1, 32));
            send({$urandom(), $urandom(), $urandom(), $urandom()}, p, ($urandom_range(0, 3) != 0), len);
            if ($urandom_range(0, 1) == 1) begin
                in_valid = 1'b0;
                repeat ($urandom_range(0, 3)) begin
                    @(posedge clk);
                    #1;
                end
            end
        end
        in_valid = 1'b0;
        wait_idle();
        rand_ready = 0;
        tx_ready = 1'b1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

endmodule
